// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants, external-master FSM encoding and the
//               byte-address to word-index helper used by the data memory
//               arbiter and the instruction ROM mapping in the wrapper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam logic [31:0] DMEM_OFFSET_DEF = 32'h10010000;
  localparam logic [31:0] IMEM_OFFSET_DEF = 32'h00400000;

  localparam int EXT_STATE_W = 1;

  typedef enum logic [EXT_STATE_W-1:0] {
    EXT_IDLE = 1'b0,
    EXT_ACK  = 1'b1
  } ext_state_t;

  // Full 32-bit word index; callers truncate to their memory depth.
  function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                input logic [31:0] offset);
    return (addr - offset) >> 2;
  endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_addr_map.sv
`default_nettype none
// ============================================================================
// Module      : dmem_addr_map
// Description : Maps a byte address onto a word index of the data memory and
//               flags whether the address falls inside the memory window.
// Ports       : addr     in  32          byte address
//               index    out DEPTH_LOG2  truncated word index
//               in_range out 1           addr in [OFFSET, OFFSET + 4*2^DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_addr_map
  import dmem_pkg::*;
#(
  parameter logic [31:0] DMEM_OFFSET = DMEM_OFFSET_DEF,
  parameter int          DEPTH_LOG2  = 11
) (
  input  logic [31:0]           addr,
  output logic [DEPTH_LOG2-1:0] index,
  output logic                  in_range
);

  logic [31:0] w_word;

  assign w_word   = addr_to_index(addr, DMEM_OFFSET);
  assign index    = w_word[DEPTH_LOG2-1:0];
  // Addresses below the base wrap to a huge difference, so a single
  // unsigned upper-bits test covers both ends of the window.
  assign in_range = (w_word[31:DEPTH_LOG2] == '0);

endmodule : dmem_addr_map
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the CPU data port
//               and one external bus master. The CPU normally wins; after
//               MAX_CPU_STREAK consecutive CPU grants with the master waiting,
//               the master gets one cycle and the CPU is stalled.
// Ports       : clk_in, reset                 clock, sync active-high reset
//               cpu_req/we/addr/wdata         CPU access request
//               cpu_rdata, cpu_stall          CPU read data and hold
//               m_req/we/addr/wdata           external master request
//               m_ack, m_rdata                completion pulse, captured data
//               mem_addr/we/wdata, mem_rdata  memory side (async read)
//               range_err                     sticky out-of-window flag
//                                             (only with DMEM_RANGE_CHECK_EN)
// Config      : DMEM_RANGE_CHECK_EN - suppress out-of-window writes, read 0
//               for them and export range_err.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter logic [31:0] DMEM_OFFSET    = DMEM_OFFSET_DEF,
  parameter int          DEPTH_LOG2     = 11,
  parameter int          MAX_CPU_STREAK = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  m_req,
  input  logic                  m_we,
  input  logic [31:0]           m_addr,
  input  logic [31:0]           m_wdata,
  output logic                  m_ack,
  output logic [31:0]           m_rdata,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic                  range_err
`endif
);

  localparam logic [3:0] c_max_streak = MAX_CPU_STREAK[3:0];

  logic [DEPTH_LOG2-1:0] w_cpu_idx;
  logic [DEPTH_LOG2-1:0] w_m_idx;
  logic                  w_cpu_in;
  logic                  w_m_in;
  logic                  w_cpu_ok;
  logic                  w_m_ok;
  logic                  w_ext_elig;
  logic                  w_ext_gnt;
  logic                  w_cpu_gnt;
  ext_state_t            r_state;
  ext_state_t            w_state_nxt;
  logic [3:0]            r_streak;
  logic [31:0]           r_m_rdata;

  dmem_addr_map #(.DMEM_OFFSET(DMEM_OFFSET), .DEPTH_LOG2(DEPTH_LOG2)) u_map_cpu (
    .addr     (cpu_addr),
    .index    (w_cpu_idx),
    .in_range (w_cpu_in)
  );

  dmem_addr_map #(.DMEM_OFFSET(DMEM_OFFSET), .DEPTH_LOG2(DEPTH_LOG2)) u_map_m (
    .addr     (m_addr),
    .index    (w_m_idx),
    .in_range (w_m_in)
  );

`ifdef DMEM_RANGE_CHECK_EN
  assign w_cpu_ok = w_cpu_in;
  assign w_m_ok   = w_m_in;
`else
  // Without checking every address is accepted and simply wraps.
  logic w_unused_range;
  assign w_unused_range = w_cpu_in ^ w_m_in;
  assign w_cpu_ok = 1'b1;
  assign w_m_ok   = 1'b1;
`endif

  // ---------------------------------------------------------------- grant
  assign w_ext_elig = m_req & (r_state == EXT_IDLE);
  assign w_ext_gnt  = w_ext_elig & (~cpu_req | (r_streak >= c_max_streak));
  assign w_cpu_gnt  = cpu_req & ~w_ext_gnt;
  assign cpu_stall  = cpu_req & ~w_cpu_gnt;

  // With no grant the address still follows the CPU so its reads settle.
  assign mem_addr  = w_ext_gnt ? w_m_idx : w_cpu_idx;
  assign mem_wdata = w_ext_gnt ? m_wdata : cpu_wdata;
  assign mem_we    = (w_ext_gnt & m_we & w_m_ok) | (w_cpu_gnt & cpu_we & w_cpu_ok);
  assign cpu_rdata = w_cpu_ok ? mem_rdata : 32'h0;
  assign m_rdata   = r_m_rdata;

  // ------------------------------------------------------ ext FSM: state
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= EXT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------- ext FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EXT_IDLE: if (w_ext_gnt) w_state_nxt = EXT_ACK;
      EXT_ACK:  w_state_nxt = EXT_IDLE;
      default:  w_state_nxt = EXT_IDLE;
    endcase
  end

  // ------------------------------------------------------ ext FSM: output
  always_comb begin
    m_ack = 1'b0;
    case (r_state)
      EXT_ACK: m_ack = 1'b1;
      default: m_ack = 1'b0;
    endcase
  end

  // ------------------------------------------------ read capture, streak
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_m_rdata <= 32'h0;
      r_streak  <= 4'd0;
    end else begin
      if (w_ext_gnt) begin
        r_m_rdata <= w_m_ok ? mem_rdata : 32'h0;
      end
      // The streak only counts while the master is actually waiting.
      if (w_ext_gnt || !w_ext_elig) begin
        r_streak <= 4'd0;
      end else if (w_cpu_gnt && r_streak != 4'd15) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic r_range_err;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_range_err <= 1'b0;
    end else if ((w_cpu_gnt & ~w_cpu_ok) | (w_ext_gnt & ~w_m_ok)) begin
      r_range_err <= 1'b1;
    end
  end

  assign range_err = r_range_err;
`endif

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a small
//               asynchronous-read memory attached to the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_RANGE_CHECK_EN
  logic        range_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_model [0:2047];

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (mem_we) mem_model[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_model[mem_addr];

  dmem_arbiter #(.DMEM_OFFSET(32'h10010000), .DEPTH_LOG2(11), .MAX_CPU_STREAK(4)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ack     (m_ack),
    .m_rdata   (m_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .range_err (range_err)
`endif
  );

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 32'h10010000; cpu_wdata = 0;
    m_req = 0; m_we = 0; m_addr = 32'h10010000; m_wdata = 0;
  endtask

  // Inputs change on the falling edge; checks happen 2 time units later.
  task automatic test_reset();
    @(negedge clk_in); #2;
    total++; if (m_ack !== 1'b0) begin $display("FAIL reset_ack: got %b want 0", m_ack); bad++; end
    total++; if (m_rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h want 0", m_rdata); bad++; end
    total++; if (cpu_stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", cpu_stall); bad++; end
    total++; if (mem_we !== 1'b0) begin $display("FAIL reset_we: got %b want 0", mem_we); bad++; end
    @(negedge clk_in); reset = 0;
  endtask

  task automatic test_cpu_only();
    @(negedge clk_in);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10010008; cpu_wdata = 32'hDEADBEEF; #2;
    total++; if (mem_addr !== 11'd2) begin $display("FAIL cpu_wr_addr: got %0d want 2", mem_addr); bad++; end
    total++; if (mem_we !== 1'b1) begin $display("FAIL cpu_wr_we: got %b want 1", mem_we); bad++; end
    total++; if (mem_wdata !== 32'hDEADBEEF) begin $display("FAIL cpu_wr_data: got %h want deadbeef", mem_wdata); bad++; end
    total++; if (cpu_stall !== 1'b0) begin $display("FAIL cpu_wr_stall: got %b want 0", cpu_stall); bad++; end
    @(negedge clk_in);
    cpu_we = 0; #2;
    total++; if (mem_addr !== 11'd2) begin $display("FAIL cpu_rd_addr: got %0d want 2", mem_addr); bad++; end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin $display("FAIL cpu_rd_data: got %h want deadbeef", cpu_rdata); bad++; end
    total++; if (cpu_stall !== 1'b0) begin $display("FAIL cpu_rd_stall: got %b want 0", cpu_stall); bad++; end
    @(negedge clk_in); idle_inputs();
  endtask

  task automatic test_ext_only();
    @(negedge clk_in);
    m_req = 1; m_we = 1; m_addr = 32'h10010010; m_wdata = 32'h12345678; #2;
    total++; if (mem_addr !== 11'd4) begin $display("FAIL ext_wr_addr: got %0d want 4", mem_addr); bad++; end
    total++; if (mem_we !== 1'b1) begin $display("FAIL ext_wr_we: got %b want 1", mem_we); bad++; end
    total++; if (m_ack !== 1'b0) begin $display("FAIL ext_wr_early_ack: got %b want 0", m_ack); bad++; end
    @(negedge clk_in); #2;
    total++; if (m_ack !== 1'b1) begin $display("FAIL ext_wr_ack: got %b want 1", m_ack); bad++; end
    total++; if (mem_we !== 1'b0) begin $display("FAIL ext_ack_no_regrant: got %b want 0", mem_we); bad++; end
    @(negedge clk_in);
    m_we = 0; #2;
    total++; if (m_ack !== 1'b0) begin $display("FAIL ext_ack_width: got %b want 0", m_ack); bad++; end
    total++; if (mem_addr !== 11'd4) begin $display("FAIL ext_rd_addr: got %0d want 4", mem_addr); bad++; end
    @(negedge clk_in); #2;
    total++; if (m_ack !== 1'b1) begin $display("FAIL ext_rd_ack: got %b want 1", m_ack); bad++; end
    total++; if (m_rdata !== 32'h12345678) begin $display("FAIL ext_rd_data: got %h want 12345678", m_rdata); bad++; end
    @(negedge clk_in); idle_inputs(); #2;
    total++; if (m_ack !== 1'b0) begin $display("FAIL ext_rd_ack_drop: got %b want 0", m_ack); bad++; end
  endtask

  task automatic test_contention();
    logic exp_stall, exp_ack;
    logic [10:0] exp_addr;
    @(negedge clk_in);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10010000;
    m_req = 1; m_we = 0; m_addr = 32'h10010004;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk_in);
      #2;
      exp_stall = (c % 6 == 4);
      exp_ack   = (c % 6 == 5);
      exp_addr  = (c % 6 == 4) ? 11'd1 : 11'd0;
      total++; if (cpu_stall !== exp_stall) begin $display("FAIL cont_stall c%0d: got %b want %b", c, cpu_stall, exp_stall); bad++; end
      total++; if (m_ack !== exp_ack) begin $display("FAIL cont_ack c%0d: got %b want %b", c, m_ack, exp_ack); bad++; end
      total++; if (mem_addr !== exp_addr) begin $display("FAIL cont_addr c%0d: got %0d want %0d", c, mem_addr, exp_addr); bad++; end
    end
    @(negedge clk_in); idle_inputs();
  endtask

  task automatic test_write_race();
    @(negedge clk_in);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10010000;
    m_req = 1; m_we = 1; m_addr = 32'h10010020; m_wdata = 32'h5555FFFF;
    repeat (3) @(negedge clk_in);
    @(negedge clk_in);
    cpu_we = 1; cpu_addr = 32'h10010020; cpu_wdata = 32'hAAAA0000; #2;
    total++; if (cpu_stall !== 1'b1) begin $display("FAIL race_stall: got %b want 1", cpu_stall); bad++; end
    total++; if (mem_wdata !== 32'h5555FFFF) begin $display("FAIL race_first_data: got %h want 5555ffff", mem_wdata); bad++; end
    total++; if (mem_addr !== 11'd8) begin $display("FAIL race_addr: got %0d want 8", mem_addr); bad++; end
    @(negedge clk_in); #2;
    total++; if (mem_model[8] !== 32'h5555FFFF) begin $display("FAIL race_ext_commit: got %h want 5555ffff", mem_model[8]); bad++; end
    total++; if (m_ack !== 1'b1) begin $display("FAIL race_ack: got %b want 1", m_ack); bad++; end
    total++; if (cpu_stall !== 1'b0 || mem_wdata !== 32'hAAAA0000) begin
      $display("FAIL race_cpu_replay: got stall=%b data=%h want stall=0 data=aaaa0000", cpu_stall, mem_wdata); bad++; end
    @(negedge clk_in);
    m_req = 0; cpu_we = 0; #2;
    total++; if (cpu_rdata !== 32'hAAAA0000) begin $display("FAIL race_final: got %h want aaaa0000", cpu_rdata); bad++; end
    @(negedge clk_in); idle_inputs();
  endtask

  task automatic test_reset_inflight();
    @(negedge clk_in);
    m_req = 1; m_we = 0; m_addr = 32'h10010010; #2;
    total++; if (mem_addr !== 11'd4) begin $display("FAIL rst_grant_addr: got %0d want 4", mem_addr); bad++; end
    @(negedge clk_in);
    reset = 1; m_req = 0;
    @(negedge clk_in); #2;
    total++; if (m_ack !== 1'b0) begin $display("FAIL rst_ack_cleared: got %b want 0", m_ack); bad++; end
    total++; if (dut.r_state !== EXT_IDLE) begin $display("FAIL rst_state: got %b want 0", dut.r_state); bad++; end
    total++; if (dut.r_streak !== 4'd0) begin $display("FAIL rst_streak: got %0d want 0", dut.r_streak); bad++; end
    total++; if (m_rdata !== 32'h0) begin $display("FAIL rst_rdata: got %h want 0", m_rdata); bad++; end
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in); #2;
      total++; if (m_ack !== 1'b0) begin $display("FAIL rst_spurious_ack c%0d: got %b want 0", c, m_ack); bad++; end
    end
  endtask

`ifdef DMEM_RANGE_CHECK_EN
  task automatic test_range_check();
    @(negedge clk_in);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10010000; cpu_wdata = 32'hCAFE0001;
    @(negedge clk_in);
    cpu_addr = 32'h10000000; cpu_wdata = 32'hBAD0BAD0; #2;
    total++; if (mem_we !== 1'b0) begin $display("FAIL range_we: got %b want 0", mem_we); bad++; end
    total++; if (range_err !== 1'b0) begin $display("FAIL range_err_early: got %b want 0", range_err); bad++; end
    @(negedge clk_in);
    cpu_we = 0; cpu_addr = 32'h10010000; #2;
    total++; if (range_err !== 1'b1) begin $display("FAIL range_err_set: got %b want 1", range_err); bad++; end
    total++; if (cpu_rdata !== 32'hCAFE0001) begin $display("FAIL range_read: got %h want cafe0001", cpu_rdata); bad++; end
    @(negedge clk_in); idle_inputs();
    @(negedge clk_in); #2;
    total++; if (range_err !== 1'b1) begin $display("FAIL range_err_sticky: got %b want 1", range_err); bad++; end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) mem_model[i] = 32'h0;
    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clk_in);
    test_reset();
    test_cpu_only();
    test_ext_only();
    test_contention();
    test_write_race();
    test_reset_inflight();
`ifdef DMEM_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
